imem_boot_loader: RTL and testbench

//  Byte-stream writer that fills instruction memory before the single-cycle MIPS core runs.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/imem_boot_loader_word_assembler.sv | 55 +++++
 rtl/imem_boot_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory boot loader: loader state
// encoding, the default frame start byte and a small state helper.
package mips_pkg;

    // Loader sequencing states, in frame order, followed by the two terminal states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_e;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

    // Terminal states stop consuming bytes until a restart.
    function automatic logic accepts_bytes(input loader_state_e s);
        return !((s == ST_DONE) || (s == ST_ERROR));
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Byte-to-word assembler: shifts payload bytes MSB first into a 32-bit word,
// tracks the byte position inside the word and keeps the running XOR checksum.
module imem_word_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic [31:0] word_o,
    output logic [7:0]  checksum_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;

    // The completed word is presented combinationally with the 4th byte so the
    // parent can register it on the very edge that consumes that byte.
    always_comb begin
        word_done_o = byte_valid_i && (idx_q == 2'd3);
        word_o      = {shift_q, byte_i};
        checksum_o  = csum_q;
    end

    // Next-state for shift register, byte index and checksum.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        if (clear_i) begin
            shift_d = '0;
            idx_d   = '0;
            csum_d  = '0;
        end else if (byte_valid_i) begin
            shift_d = {shift_q[15:0], byte_i};
            idx_d   = idx_q + 2'd1;
            csum_d  = csum_q ^ byte_i;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses MAGIC, 16-bit word count, N big-endian words and an XOR
// checksum from a valid/ready byte stream, writes each word into instruction
// memory and releases the core's reset only once the image has verified.
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 256,
    parameter logic [7:0]            MAGIC      = DEFAULT_MAGIC
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    input  logic [7:0]            in_data_i,
    output logic                  in_ready_o,
    input  logic                  restart_i,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  cpu_reset_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam logic [16:0]           MAX_WORDS_W = 17'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(4);

    loader_state_e         state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [15:0]           n_words_q, n_words_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;

    logic        xfer;
    logic        restart_fire;
    logic        asm_valid;
    logic        word_done;
    logic [31:0] word;
    logic [7:0]  checksum;
    logic [15:0] len_full;

    // Handshake and frame-field decode shared by the FSM and the assembler.
    always_comb begin
        in_ready_o   = accepts_bytes(state_q);
        xfer         = in_valid_i && in_ready_o;
        restart_fire = restart_i && !accepts_bytes(state_q);
        asm_valid    = xfer && (state_q == ST_DATA);
        len_full     = {len_hi_q, in_data_i};
    end

    imem_word_assembler u_asm (
        .clk_i        (clk_i),
        .rst_i        (reset_i),
        .clear_i      (restart_fire),
        .byte_valid_i (asm_valid),
        .byte_i       (in_data_i),
        .word_done_o  (word_done),
        .word_o       (word),
        .checksum_o   (checksum)
    );

    // Next-state logic: frame sequencing, word counting and write address.
    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        n_words_d  = n_words_q;
        word_cnt_d = word_cnt_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        // The address is held through the write pulse and steps right after it.
        addr_d     = we_q ? (addr_q + ADDR_STEP) : addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (xfer && (in_data_i == MAGIC)) begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_data_i;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    n_words_d = len_full;
                    if ({1'b0, len_full} > MAX_WORDS_W) begin
                        state_d = ST_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_done) begin
                    wdata_d    = word;
                    we_d       = 1'b1;
                    word_cnt_d = word_cnt_q + 16'd1;
                    if ((word_cnt_q + 16'd1) == n_words_q) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    state_d = (in_data_i == checksum) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (restart_fire) begin
                    state_d    = ST_IDLE;
                    len_hi_d   = '0;
                    n_words_d  = '0;
                    word_cnt_d = '0;
                    addr_d     = BASE_ADDR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered state; reset aborts any frame in progress immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            len_hi_q   <= '0;
            n_words_q  <= '0;
            word_cnt_q <= '0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            n_words_q  <= n_words_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
        end
    end

    // Status outputs decode directly from the registered state, so done and
    // error are mutually exclusive and the core runs only in DONE.
    always_comb begin
        imem_we_o    = we_q;
        imem_addr_o  = addr_q;
        imem_wdata_o = wdata_q;
        done_o       = (state_q == ST_DONE);
        error_o      = (state_q == ST_ERROR);
        cpu_reset_o  = (state_q != ST_DONE);
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for the boot loader: frames are generated from word lists, and the
// expected writes, addresses and final status follow from the frame contents.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        restart;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    imem_boot_loader dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .restart_i    (restart),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .cpu_reset_o  (cpu_reset),
        .done_o       (done),
        .error_o      (error)
    );

    int total  = 0;
    int passed = 0;

    // Write-strobe monitor: counts pulses and flags any pulse longer than a cycle.
    int wr_count   = 0;
    int we_run     = 0;
    bit wide_seen  = 1'b0;
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_count <= wr_count + 1;
            we_run   <= we_run + 1;
            if (we_run >= 1) wide_seen <= 1'b1;
        end else begin
            we_run <= 0;
        end
    end

    logic [31:0] frame_words[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one byte for one edge, optionally after a random idle gap with junk data.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            int n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, in_ready, 1);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_cpurst"}, cpu_reset, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    task automatic do_restart(input string tag);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_idle_outputs(tag);
    endtask

    // Sends a complete frame built from frame_words; every word's write is
    // checked on the cycle right after its 4th byte.
    task automatic send_frame(input bit good_csum, input bit gaps, input int prefix, input string tag);
        logic [7:0] cs;
        logic [7:0] b;
        logic [15:0] n;
        n  = 16'(frame_words.size());
        cs = 8'h00;
        for (int p = 0; p < prefix; p++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send_byte(b, gaps);
        end
        send_byte(8'hA5, gaps);
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        for (int i = 0; i < frame_words.size(); i++) begin
            for (int j = 3; j >= 0; j--) begin
                b  = frame_words[i][8*j +: 8];
                cs = cs ^ b;
                send_byte(b, gaps);
            end
            chk({tag, "_we"}, imem_we, 1);
            chk({tag, "_waddr"}, imem_addr, 32'(4 * i));
            chk({tag, "_wdata"}, imem_wdata, frame_words[i]);
        end
        send_byte(good_csum ? cs : (cs ^ 8'h5A), gaps);
        $display("frame %s: N=%0d csum_ok=%0d gaps=%0d prefix=%0d", tag, n, good_csum, gaps, prefix);
    endtask

    task automatic expect_end(input bit good, input int nwr, input int base_cnt, input string tag);
        tick();
        chk({tag, "_done"}, done, good);
        chk({tag, "_error"}, error, !good);
        chk({tag, "_cpurst"}, cpu_reset, !good);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_nwr"}, 32'(wr_count - base_cnt), 32'(nwr));
        chk({tag, "_addr"}, imem_addr, 32'(4 * nwr));
    endtask

    task automatic random_words(input int n);
        frame_words.delete();
        for (int i = 0; i < n; i++) begin
            frame_words.push_back(($urandom_range(0, 4) == 0) ? 32'hA5A5A5A5 : $urandom);
        end
    endtask

    initial begin
        int base;
        int n;
        bit good;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;
        tick();
        chk("rst_wdata", imem_wdata, 32'h0);
        check_idle_outputs("rst");
        tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("post_rst");

        // Two-instruction program, good checksum.
        frame_words = '{32'h20080005, 32'h2009000A};
        base = wr_count;
        send_frame(1'b1, 1'b0, 0, "t1");
        expect_end(1'b1, 2, base, "t1");
        // Bytes offered in DONE are ignored; a restart re-arms the loader.
        send_byte(8'hA5, 1'b0);
        chk("t1_hold_done", done, 1);
        do_restart("t1_rs");

        // Same program, bad checksum: writes still happen, then error.
        base = wr_count;
        send_frame(1'b0, 1'b0, 0, "t2");
        expect_end(1'b0, 2, base, "t2");
        do_restart("t2_rs");

        // Garbage before the magic byte, MAGIC-valued words inside the payload.
        frame_words = '{32'hA5A5A5A5, 32'h8C080000, 32'h00A5A500};
        base = wr_count;
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h5A, 1'b0);
        tick();
        chk("t3_garbage_nwr", 32'(wr_count - base), 0);
        chk("t3_garbage_ready", in_ready, 1);
        send_frame(1'b1, 1'b0, 0, "t3");
        expect_end(1'b1, 3, base, "t3");
        do_restart("t3_rs");

        // Oversize count: error right after the low length byte.
        base = wr_count;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("t4_mid_error", error, 0);
        send_byte(8'h01, 1'b0);
        chk("t4_error_now", error, 1);
        expect_end(1'b0, 0, base, "t4");
        do_restart("t4_rs");

        // Empty image; a restart pulse mid-frame must be ignored.
        base = wr_count;
        send_byte(8'hA5, 1'b0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t5_restart_ignored_ready", in_ready, 1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        expect_end(1'b1, 0, base, "t5");
        do_restart("t5_rs");

        // Reset in the middle of word 1, asserted between edges.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_wdata", imem_wdata, 32'h0);
        check_idle_outputs("t6_async");
        tick();
        reset = 1'b0;
        random_words(4);
        base = wr_count;
        send_frame(1'b1, 1'b0, 0, "t6a");
        expect_end(1'b1, 4, base, "t6a");
        do_restart("t6a_rs");
        base = wr_count;
        send_frame(1'b1, 1'b1, 0, "t6b");
        expect_end(1'b1, 4, base, "t6b");
        do_restart("t6b_rs");

        // Largest accepted image.
        random_words(256);
        base = wr_count;
        send_frame(1'b1, 1'b0, 0, "max");
        expect_end(1'b1, 256, base, "max");
        do_restart("max_rs");

        // Randomised frames with gaps, garbage prefixes and either checksum.
        for (int r = 0; r < 6; r++) begin
            n    = $urandom_range(1, 6);
            good = 1'($urandom_range(0, 1));
            random_words(n);
            base = wr_count;
            send_frame(good, 1'b1, $urandom_range(0, 2), "rnd");
            expect_end(good, n, base, "rnd");
            do_restart("rnd_rs");
        end

        chk("we_single_cycle", 32'(wide_seen), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
